// File: rtl/disp_share_arb_pkg.sv
// disp_share_arb_pkg: shared display constants, arbiter state enum and leading-zero blank helper
package disp_share_arb_pkg;
  localparam int DISP_DIGITS = 4;
  localparam int NIB_W = 4;
  localparam int DISP_W = DISP_DIGITS * NIB_W;
  localparam logic [DISP_DIGITS-1:0] BLANK_ALL = 4'b1111;
  typedef enum logic [1:0] {IDLE, OWN, GAP} state_e;
  // A digit is blanked when it and every higher digit are zero; digit 0 always shows.
  function automatic logic [DISP_DIGITS-1:0] lz_blank(input logic [DISP_W-1:0] v);
    logic [DISP_DIGITS-1:0] b;
    b[3] = v[15:12] == 4'h0;
    b[2] = b[3] && v[11:8] == 4'h0;
    b[1] = b[2] && v[7:4] == 4'h0;
    b[0] = 1'b0;
    return b;
  endfunction
endpackage

// File: rtl/disp_rr_pick.sv
// disp_rr_pick: combinational round-robin picker, search starts just after last_i
module disp_rr_pick #(
  parameter int N_REQ = 3,
  parameter int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    last_i,
  output logic [IW-1:0]    idx_o,
  output logic             found_o
);
  // Scan from farthest to nearest so the nearest requester after last_i wins.
  always_comb begin
    idx_o = '0;
    found_o = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % N_REQ]) begin
        found_o = 1'b1;
        idx_o = IW'((int'(last_i) + k) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/disp_share_arb.sv
// disp_share_arb: round-robin owner of the 4-digit hex display; DISP_SHARE_LZ_BLANK_EN enables leading-zero blanking
module disp_share_arb
  import disp_share_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [DISP_W*N_REQ-1:0]  data,
  output logic [N_REQ-1:0]         grant,
  output logic [DISP_W-1:0]        disp_val,
  output logic                     disp_valid,
  output logic [DISP_DIGITS-1:0]   blank
);
  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, pick_idx;
  logic pick_found, hold_done, others;
  logic [HW-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] grant_d;
  logic [DISP_W-1:0] val_d;
  logic valid_d;
  logic [DISP_DIGITS-1:0] blank_d;

  disp_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req_i(req),
    .last_i(last_q),
    .idx_o(pick_idx),
    .found_o(pick_found)
  );

  assign hold_done = hold_q == HOLD_MAX;
  assign others = |(req & ~(N_REQ'(1) << owner_q));

  // Ownership FSM: grant on any request, release on drop or on hold expiry with contention.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    hold_d = '0;
    case (state_q)
      IDLE: begin
        state_d = pick_found ? OWN : IDLE;
        owner_d = pick_found ? pick_idx : owner_q;
      end
      OWN: begin
        hold_d = hold_done ? hold_q : hold_q + 1'b1;
        state_d = (!req[owner_q] || (hold_done && others)) ? GAP : OWN;
      end
      GAP: begin
        last_d = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port is a plain register.
  always_comb begin
    valid_d = state_d == OWN;
    grant_d = valid_d ? N_REQ'(1) << owner_d : '0;
    val_d = valid_d ? data[{owner_d, 4'b0000} +: DISP_W] : disp_val;
`ifdef DISP_SHARE_LZ_BLANK_EN
    blank_d = valid_d ? lz_blank(val_d) : BLANK_ALL;
`else
    blank_d = {DISP_DIGITS{~valid_d}};
`endif
  end

  // State, counters and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= IW'(N_REQ - 1);
      hold_q <= '0;
      grant <= '0;
      disp_val <= '0;
      disp_valid <= 1'b0;
      blank <= BLANK_ALL;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      hold_q <= hold_d;
      grant <= grant_d;
      disp_val <= val_d;
      disp_valid <= valid_d;
      blank <= blank_d;
    end
  end
endmodule

// File: tb/tb_disp_share_arb.sv
// tb_disp_share_arb: table-driven check of arbitration, hold, release, reset and blanking
module tb_disp_share_arb;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] req;
  logic [47:0] data;
  logic [2:0] grant;
  logic [15:0] disp_val;
  logic disp_valid;
  logic [3:0] blank;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic rst;
    logic [2:0] req;
    logic [15:0] d0, d1, d2;
    logic [2:0] g;
    logic [15:0] v;
    logic vv;
    logic [3:0] bz;
  } vec_t;
  vec_t tab[$];

  localparam logic [15:0] D0 = 16'h0070;
  localparam logic [15:0] D1 = 16'h1234;
  localparam logic [15:0] D2 = 16'h0000;
  localparam logic [15:0] BF = 16'hBEEF;

  disp_share_arb #(.N_REQ(3), .HOLD_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .data(data),
    .grant(grant),
    .disp_val(disp_val),
    .disp_valid(disp_valid),
    .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [2:0] q, input logic [15:0] a, b, c,
                     input logic [2:0] g, input logic [15:0] v, input logic vv,
                     input logic [3:0] bz, input int n = 1);
    vec_t e;
    e.rst = r; e.req = q; e.d0 = a; e.d1 = b; e.d2 = c;
    e.g = g; e.v = v; e.vv = vv; e.bz = bz;
    for (int i = 0; i < n; i++) tab.push_back(e);
  endtask

  task automatic chk(input string nm, input int row, input logic [15:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  initial begin
    int n, k;
    logic [3:0] eb;
    rst = 1'b1;
    req = '0;
    data = '0;
    add(1, 3'b000, D0, D1, D2, 3'b000, 16'h0000, 0, 4'hF);
    add(0, 3'b111, D0, D1, D2, 3'b001, D0, 1, 4'b1100, 5);
    add(0, 3'b111, D0, D1, D2, 3'b000, D0, 0, 4'hF, 2);
    add(0, 3'b111, D0, D1, D2, 3'b010, D1, 1, 4'b0000, 5);
    add(0, 3'b111, D0, D1, D2, 3'b000, D1, 0, 4'hF, 2);
    add(0, 3'b111, D0, D1, D2, 3'b100, D2, 1, 4'b1110, 5);
    add(0, 3'b111, D0, D1, D2, 3'b000, D2, 0, 4'hF, 2);
    add(0, 3'b111, D0, D1, D2, 3'b001, D0, 1, 4'b1100);
    add(1, 3'b000, D0, D1, D2, 3'b000, 16'h0000, 0, 4'hF);
    add(0, 3'b010, D0, D1, D2, 3'b010, D1, 1, 4'b0000);
    add(0, 3'b010, D0, BF, D2, 3'b010, BF, 1, 4'b0000, 6);
    add(1, 3'b010, D0, BF, D2, 3'b000, 16'h0000, 0, 4'hF);
    add(0, 3'b110, D0, BF, D2, 3'b010, BF, 1, 4'b0000);
    add(0, 3'b000, D0, BF, D2, 3'b000, BF, 0, 4'hF, 3);
    add(0, 3'b001, D0, BF, D2, 3'b001, D0, 1, 4'b1100);
    add(0, 3'b101, D0, BF, D2, 3'b001, D0, 1, 4'b1100, 4);
    add(0, 3'b101, D0, BF, D2, 3'b000, D0, 0, 4'hF, 2);
    add(0, 3'b101, D0, BF, D2, 3'b100, D2, 1, 4'b1110);
    add(0, 3'b000, D0, BF, D2, 3'b000, D2, 0, 4'hF, 2);
    add(0, 3'b011, D0, D1, D2, 3'b001, D0, 1, 4'b1100);
    add(0, 3'b010, D0, D1, D2, 3'b000, D0, 0, 4'hF, 2);
    add(0, 3'b010, 16'hxxxx, D1, 16'hxxxx, 3'b010, D1, 1, 4'b0000);
    add(0, 3'b000, D0, D1, D2, 3'b000, D1, 0, 4'hF);
    foreach (tab[i]) begin
      @(negedge clk);
      rst = tab[i].rst;
      req = tab[i].req;
      data = {tab[i].d2, tab[i].d1, tab[i].d0};
      @(posedge clk);
      #1;
`ifdef DISP_SHARE_LZ_BLANK_EN
      eb = tab[i].vv ? tab[i].bz : 4'hF;
`else
      eb = tab[i].vv ? 4'h0 : 4'hF;
`endif
      chk("grant", i, 16'(grant), 16'(tab[i].g));
      chk("disp_val", i, disp_val, tab[i].v);
      chk("disp_valid", i, 16'(disp_valid), 16'(tab[i].vv));
      chk("blank", i, 16'(blank), 16'(eb));
    end
    // Contended ownership length and dark handover gap, measured with bounded waits.
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    data = {D2, D1, D0};
    @(negedge clk);
    rst = 1'b0;
    req = 3'b101;
    n = 0;
    for (int i = 0; i < 20 && (n == 0 || grant == 3'b001); i++) begin
      @(posedge clk);
      #1;
      if (grant == 3'b001) n++;
    end
    chk("hold_len", -1, 16'(n), 16'd5);
    k = 1;
    for (int i = 0; i < 10 && grant != 3'b100; i++) begin
      @(posedge clk);
      #1;
      if (grant != 3'b100) k++;
    end
    chk("dark_gap", -1, 16'(k), 16'd2);
    chk("next_owner", -1, 16'(grant), 16'(3'b100));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
